// File: rtl/control_sequencer.sv
// Instruction phase sequencer: walks IF/ID/EX/MEM/WB, handles two-word fetch,
// multi-cycle/stalled MEM, interrupt entry and the one-instruction inhibit after RETI.
module control_sequencer #(
  parameter int STATE_WIDTH = 3,
  parameter int ST_IF  = 0,
  parameter int ST_ID  = 1,
  parameter int ST_EX  = 2,
  parameter int ST_MEM = 3,
  parameter int ST_WB  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic                   two_word,
  input  logic                   has_mem,
  input  logic                   mem_two_cycle,
  input  logic                   is_reti,
  input  logic                   mem_wait,
  input  logic                   irq_req,
  input  logic                   irq_enable,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   cycle_count,
  output logic                   isr_entry,
  output logic                   fetch_en,
  output logic                   retire
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IF  = STATE_WIDTH'(ST_IF),
    S_ID  = STATE_WIDTH'(ST_ID),
    S_EX  = STATE_WIDTH'(ST_EX),
    S_MEM = STATE_WIDTH'(ST_MEM),
    S_WB  = STATE_WIDTH'(ST_WB)
  } state_t;

  state_t r_state, w_nxt;
  logic   r_cc, r_isr, r_hm, r_tc, r_reti, r_inh;
  logic   w_cc_nxt, w_isr_nxt, w_hm_nxt, w_tc_nxt, w_reti_nxt, w_inh_nxt;
  logic   w_take, w_fetch, w_retire;

  // Interrupts are only accepted at an instruction boundary; reset keeps fetch_en high.
  assign w_take = (r_state == S_IF) && !r_cc && irq_req && irq_enable && !r_inh && reset;

  always_comb begin
    w_nxt      = r_state;
    w_cc_nxt   = r_cc;
    w_isr_nxt  = r_isr;
    w_hm_nxt   = r_hm;
    w_tc_nxt   = r_tc;
    w_reti_nxt = r_reti;
    w_inh_nxt  = r_inh;
    w_fetch    = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_IF: begin
        w_fetch = !w_take;
        if (w_take) begin
          w_nxt     = S_ID;
          w_isr_nxt = 1'b1;
          w_cc_nxt  = 1'b0;
        end else if (instr_valid) begin
          if (two_word && !r_cc) w_cc_nxt = 1'b1;
          else begin
            w_nxt    = S_ID;
            w_cc_nxt = 1'b0;
          end
        end
      end
      S_ID: begin
        // CALL_ISR pushes the return address: a two-cycle memory phase.
        w_hm_nxt   = has_mem | r_isr;
        w_tc_nxt   = mem_two_cycle | r_isr;
        w_reti_nxt = is_reti & ~r_isr;
        w_nxt      = S_EX;
      end
      S_EX: w_nxt = r_hm ? S_MEM : S_WB;
      S_MEM: begin
        if (!mem_wait) begin
          if (r_tc && !r_cc) w_cc_nxt = 1'b1;
          else begin
            w_nxt    = S_WB;
            w_cc_nxt = 1'b0;
          end
        end
      end
      S_WB: begin
        w_retire  = 1'b1;
        w_nxt     = S_IF;
        w_isr_nxt = 1'b0;
        // Retiring RETI blocks interrupts for exactly the next instruction.
        w_inh_nxt = r_reti;
      end
      default: w_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IF;
      r_cc    <= 1'b0;
      r_isr   <= 1'b0;
      r_hm    <= 1'b0;
      r_tc    <= 1'b0;
      r_reti  <= 1'b0;
      r_inh   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cc    <= w_cc_nxt;
      r_isr   <= w_isr_nxt;
      r_hm    <= w_hm_nxt;
      r_tc    <= w_tc_nxt;
      r_reti  <= w_reti_nxt;
      r_inh   <= w_inh_nxt;
    end
  end

  assign state       = r_state;
  assign cycle_count = r_cc;
  assign isr_entry   = r_isr;
  assign fetch_en    = w_fetch;
  assign retire      = w_retire;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model producing the
// expected per-cycle phase trace; directed scenarios followed by random instructions.
module tb_control_sequencer;
  localparam int SW = 3;
  localparam int ST_IF = 0, ST_ID = 1, ST_EX = 2, ST_MEM = 3, ST_WB = 4;

  logic clk = 1'b0;
  logic reset;
  logic instr_valid, two_word, has_mem, mem_two_cycle, is_reti, mem_wait, irq_req, irq_enable;
  logic [SW-1:0] state;
  logic cycle_count, isr_entry, fetch_en, retire;

  int n_vec = 0;
  int n_err = 0;
  bit m_isr = 0;
  bit m_inh = 0;

  control_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .two_word(two_word),
    .has_mem(has_mem), .mem_two_cycle(mem_two_cycle), .is_reti(is_reti),
    .mem_wait(mem_wait), .irq_req(irq_req), .irq_enable(irq_enable),
    .state(state), .cycle_count(cycle_count), .isr_entry(isr_entry),
    .fetch_en(fetch_en), .retire(retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s obs{st,cc,isr,fe,ret}=%b exp=%b t=%0t", tag, obs[6:0], exp_v[6:0], $time);
    end
  endtask

  function automatic logic [31:0] pk();
    return {25'b0, state, cycle_count, isr_entry, fetch_en, retire};
  endfunction

  function automatic logic [31:0] ev(input int s, input bit cc, input bit isr, input bit fe, input bit ret);
    return {25'b0, 3'(s), cc, isr, fe, ret};
  endfunction

  // Called at a negedge with inputs already driven; checks, then moves to the next negedge.
  task automatic cyc(input string tag, input logic [31:0] e);
    #1;
    chk(tag, pk(), e);
    @(negedge clk);
  endtask

  task automatic noise();
    instr_valid   = 1'($urandom_range(0, 1));
    two_word      = 1'($urandom_range(0, 1));
    has_mem       = 1'($urandom_range(0, 1));
    mem_two_cycle = 1'($urandom_range(0, 1));
    is_reti       = 1'($urandom_range(0, 1));
    mem_wait      = 1'($urandom_range(0, 1));
    irq_req       = 1'($urandom_range(0, 1));
    irq_enable    = 1'($urandom_range(0, 1));
  endtask

  // One instruction (or interrupt entry) from its first IF cycle through WB.
  task automatic do_instr(input bit dir, input bit d_irq, input bit d_two, input bit d_mem,
                          input bit d_tc, input bit d_reti, input int d_w0, input int d_w1,
                          input bit rst_m1);
    bit take, two, valid, hm, tc, rt;
    int w;
    take = 0; two = 0;
    for (int k = 0; k < 6; k++) begin
      noise();
      if (dir) begin
        instr_valid = 1'b1; irq_req = d_irq; irq_enable = d_irq; two_word = d_two;
      end else begin
        instr_valid = (k == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        irq_req     = ($urandom_range(0, 3) == 0);
      end
      take  = irq_req && irq_enable && !m_inh;
      valid = instr_valid;
      two   = two_word;
      cyc("if_cc0", ev(ST_IF, 0, 0, !take, 0));
      if (take) begin m_isr = 1; two = 0; break; end
      if (valid) break;
    end
    if (two) begin
      noise(); instr_valid = 1'b1;
      cyc("if_cc1", ev(ST_IF, 1, 0, 1, 0));
    end
    noise();
    if (dir) begin has_mem = d_mem; mem_two_cycle = d_tc; is_reti = d_reti; end
    if (m_isr) is_reti = 1'b0;
    hm = has_mem | m_isr; tc = mem_two_cycle | m_isr; rt = is_reti;
    cyc("id", ev(ST_ID, 0, m_isr, 0, 0));
    noise();
    cyc("ex", ev(ST_EX, 0, m_isr, 0, 0));
    if (hm) begin
      for (int sub = 0; sub <= int'(tc); sub++) begin
        w = dir ? ((sub == 1) ? d_w1 : d_w0) : int'($urandom_range(0, 2));
        for (int j = 0; j < w; j++) begin
          noise(); mem_wait = 1'b1;
          cyc("mem_wait", ev(ST_MEM, 1'(sub), m_isr, 0, 0));
        end
        noise(); mem_wait = 1'b0;
        if (rst_m1 && sub == 1) begin
          irq_req = 1'b0;
          #1 chk("mem_cc1_pre_rst", pk(), ev(ST_MEM, 1, m_isr, 0, 0));
          reset = 1'b0;
          #1 chk("rst_async", pk(), ev(ST_IF, 0, 0, 1, 0));
          @(negedge clk);
          #1 chk("rst_hold", pk(), ev(ST_IF, 0, 0, 1, 0));
          @(negedge clk);
          reset = 1'b1; m_isr = 0; m_inh = 0;
          return;
        end
        cyc("mem", ev(ST_MEM, 1'(sub), m_isr, 0, 0));
      end
    end
    noise();
    cyc("wb", ev(ST_WB, 0, m_isr, 0, 1));
    m_inh = rt;
    m_isr = 0;
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 0; two_word = 0; has_mem = 0; mem_two_cycle = 0;
    is_reti = 0; mem_wait = 0; irq_req = 0; irq_enable = 0;
    @(negedge clk);
    #1 chk("reset_state", pk(), ev(ST_IF, 0, 0, 1, 0));
    @(negedge clk);
    reset = 1'b1;
    do_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);  // ALU op
    do_instr(1, 0, 1, 1, 0, 0, 0, 0, 0);  // two-word LDS
    do_instr(1, 0, 0, 1, 1, 0, 2, 0, 0);  // RET stalled 2 cycles in MEM cc0
    do_instr(1, 1, 0, 0, 0, 0, 0, 0, 0);  // interrupt entry
    do_instr(1, 0, 0, 1, 1, 1, 0, 1, 0);  // RETI
    do_instr(1, 1, 0, 0, 0, 0, 0, 0, 0);  // inhibited: runs normally
    do_instr(1, 1, 0, 0, 0, 0, 0, 0, 0);  // interrupt now taken
    do_instr(1, 0, 0, 1, 1, 0, 0, 0, 1);  // reset during MEM cc1
    do_instr(1, 0, 1, 0, 0, 0, 0, 0, 0);  // normal fetch after release
    for (int i = 0; i < 200; i++) do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameters: STATE_WIDTH, default 3, state bus width; ST_IF/ST_ID/ST_EX/ST_MEM/ST_WB, defaults 0/1/2/3/4, state encodings.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  fetched instruction word is present this cycle.
- two_word  in  1  decoded instruction is 32-bit; sampled in IF.
- has_mem  in  1  instruction needs a MEM phase; sampled in ID.
- mem_two_cycle  in  1  MEM needs 2 cycles (RCALL/RET/RETI); sampled in ID.
- is_reti  in  1  instruction is RETI; sampled in ID.
- mem_wait  in  1  memory not ready; holds MEM.
- irq_req  in  1  interrupt pending.
- irq_enable  in  1  SREG I flag.
- state  out  STATE_WIDTH  current phase, to the signal generation logic.
- cycle_count  out  1  sub-cycle index within IF or MEM.
- isr_entry  out  1  the current sequence is the CALL_ISR pseudo-instruction.
- fetch_en  out  1  instruction memory read enable.
- retire  out  1  one-cycle pulse in the last WB cycle.

Function
REQ-004 SHALL use exactly five states, IF, ID, EX, MEM and WB; the encoding SHALL be registered, and no other value SHALL ever appear on state.
REQ-005 IF, no interrupt taken:
- cycle_count=0 and instr_valid=0: stay in IF.
- instr_valid=1 and two_word=1 with cycle_count=0: stay in IF, cycle_count<=1.
- otherwise with instr_valid=1: go to ID, cycle_count<=0.
REQ-006 fetch_en SHALL be 1 in IF unless an interrupt is taken that cycle; fetch_en SHALL be 0 in all other states.
REQ-007 Interrupt taken in IF when cycle_count=0, irq_req=1, irq_enable=1 and the inhibit flag is clear; the next state SHALL be ID with isr_entry<=1, regardless of instr_valid.
REQ-008 In ID, the block SHALL latch has_mem, mem_two_cycle and is_reti. While isr_entry=1 it SHALL force has_mem=1 and mem_two_cycle=1. ID SHALL always go to EX.
REQ-009 EX SHALL go to MEM if latched has_mem=1, otherwise to WB.
REQ-010 MEM:
- mem_wait=1: hold state and cycle_count.
- mem_two_cycle=1 with cycle_count=0: stay in MEM, cycle_count<=1.
- otherwise: go to WB, cycle_count<=0.
REQ-011 WB SHALL last one cycle, assert retire=1, then go to IF with cycle_count=0; isr_entry SHALL clear on that transition.
REQ-012 cycle_count SHALL be 0 in ID, EX and WB.
REQ-013 The inhibit flag SHALL be set when a RETI retires, and cleared when the following instruction retires. While the flag is set, no interrupt SHALL be taken, so exactly one instruction executes after RETI.
REQ-014 An irq_req that arrives in any state other than IF with cycle_count=0 SHALL have no effect until the next such IF cycle. A two-word fetch SHALL never be split.
REQ-015 Decoder inputs SHALL be ignored outside their sampling states.

Reset
REQ-016 While reset=0, the block SHALL force state=ST_IF, cycle_count=0, isr_entry=0, fetch_en=1 (combinational from the IF state), retire=0, all latched flags=0 and the inhibit flag=0.
REQ-017 Reset asserted mid-instruction SHALL abort that instruction with no retire pulse. After release, the first rising edge SHALL evaluate IF.

Verification
REQ-018 ALU op (has_mem=0, instr_valid=1) -> IF,ID,EX,WB; retire in cycle 4; back in IF in cycle 5.
REQ-019 Two-word LDS with has_mem=1 -> IF(cc0),IF(cc1),ID,EX,MEM,WB; 6 cycles.
REQ-020 RET (has_mem=1, mem_two_cycle=1) with mem_wait=1 for 2 cycles in MEM cc0 -> MEM held 2 cycles, then MEM cc1, then WB; 8 cycles total.
REQ-021 irq_req=1 and irq_enable=1 at IF -> fetch_en=0; isr_entry=1 through ID,EX,MEM(cc0),MEM(cc1),WB; isr_entry=0 in the next IF.
REQ-022 RETI retires while irq_req=1 -> next instruction runs as a normal instruction with isr_entry=0; the interrupt is taken in the IF after it.
REQ-023 reset pulled low during MEM cc1 -> state=ST_IF and cycle_count=0 immediately, retire never asserted; a normal fetch proceeds after release.
